alu_seq_exec: RTL and testbench

ALU_SEQ_EXEC -- requirements
Module: alu_seq_exec

---
 rtl/alu_seq_exec.sv | 117 +++++++++++
 tb/tb_alu_seq_exec.sv | 100 ++++++++++
 2 files changed

// File: rtl/alu_seq_exec.sv
// alu_seq_exec: RV32-style ALU; one-cycle arithmetic/logic ops, shifts done bit-serially one position per clock
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   start    execute request, sampled only in IDLE
//   alu_ctrl {func7 bit, func3}
//   op_a     first operand
//   op_b     second operand, low SHW bits are the shift amount
//   result   registered result, held until next completion
//   zero     registered, result == 0
//   valid    one-cycle completion pulse
//   busy     shift in progress
//   illegal  registered with result, alu_ctrl was undefined
module alu_seq_exec #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             valid,
  output logic             busy,
  output logic             illegal
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] acc_q, acc_d, result_q, result_d, alu_y, acc_sh;
  logic [SHW-1:0]   cnt_q, cnt_d, shamt;
  logic             zero_q, zero_d, valid_q, valid_d, illegal_q, illegal_d;
  logic             legal, is_shift;
  assign shamt    = op_b[SHW-1:0];
  assign is_shift = (alu_ctrl == 4'b0001 || alu_ctrl == 4'b0101 || alu_ctrl == 4'b1101) && shamt != '0;
  // SRA keeps re-inserting the accumulator MSB, which is the latched op_a sign
  assign acc_sh   = ctrl_q == 4'b0001 ? {acc_q[WIDTH-2:0], 1'b0}
                                      : {ctrl_q[3] & acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
  always_comb begin
    legal = 1'b1;
    alu_y = '0;
    case (alu_ctrl)
      4'b0000: alu_y = op_a + op_b;
      4'b1000: alu_y = op_a - op_b;
      4'b0010: alu_y = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'b0011: alu_y = {{(WIDTH-1){1'b0}}, op_a < op_b};
      4'b0100: alu_y = op_a ^ op_b;
      4'b0110: alu_y = op_a | op_b;
      4'b0111: alu_y = op_a & op_b;
      4'b0001, 4'b0101, 4'b1101: alu_y = op_a;
      default: legal = 1'b0;
    endcase
  end
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    valid_d   = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        ctrl_d = alu_ctrl;
        acc_d  = op_a;
        cnt_d  = shamt;
        if (is_shift) begin
          state_d = SHIFT;
        end else begin
          result_d  = alu_y;
          zero_d    = alu_y == '0;
          illegal_d = !legal;
          valid_d   = 1'b1;
        end
      end
    end else begin
      acc_d = acc_sh;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == SHW'(1)) begin
        state_d   = IDLE;
        result_d  = acc_sh;
        zero_d    = acc_sh == '0;
        illegal_d = 1'b0;
        valid_d   = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end
  assign result  = result_q;
  assign zero    = zero_q;
  assign valid   = valid_q;
  assign illegal = illegal_q;
  assign busy    = state_q == SHIFT;
endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: directed self-checking bench for alu_seq_exec
module tb_alu_seq_exec;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  alu_ctrl = '0;
  logic [31:0] op_a = '0, op_b = '0, result;
  logic        zero, valid, busy, illegal;
  int          checks = 0, errors = 0;
  alu_seq_exec #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .alu_ctrl(alu_ctrl),
    .op_a(op_a), .op_b(op_b), .result(result), .zero(zero),
    .valid(valid), .busy(busy), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic s, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    start = s;
    alu_ctrl = c;
    op_a = a;
    op_b = b;
  endtask
  // single-cycle op: start in current cycle, check completion in next
  task automatic one(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_r, input logic exp_z, input logic exp_i);
    drive(1'b1, c, a, b);
    step();
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    chk({tag, "_bvzi"}, {28'h0, busy, valid, zero, illegal}, {28'h0, 1'b0, 1'b1, exp_z, exp_i});
    chk({tag, "_res"}, result, exp_r);
  endtask
  // multi-cycle shift; an ADD start is pulsed mid-flight and inputs are scrambled
  task automatic shf(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                     input int n, input logic [31:0] exp_r);
    drive(1'b1, c, a, b);
    for (int i = 1; i <= n; i++) begin
      step();
      if (i == 2) drive(1'b1, 4'b0000, 32'h1, 32'h1);
      else drive(1'b0, 4'b0000, 32'hDEAD_BEEF, 32'h0000_0003);
      chk({tag, "_busy"}, {30'h0, busy, valid}, 32'h2);
    end
    step();
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    chk({tag, "_done"}, {30'h0, busy, valid}, 32'h1);
    chk({tag, "_res"}, result, exp_r);
    chk({tag, "_ill"}, {31'h0, illegal}, 32'h0);
    step();
    chk({tag, "_after"}, {30'h0, busy, valid}, 32'h0);
  endtask
  initial begin
    step();
    step();
    chk("rst_res", result, 32'h0);
    chk("rst_flags", {28'h0, busy, valid, zero, illegal}, 32'h2);
    reset_n = 1'b1;
    one("add", 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    one("sub", 4'b1000, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0);
    one("slt", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    one("sltu", 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    step();
    chk("idle_valid", {31'h0, valid}, 32'h0);
    chk("idle_hold", result, 32'h0);
    one("xor", 4'b0100, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 1'b0, 1'b0);
    one("or", 4'b0110, 32'hA000_0005, 32'h0500_0050, 32'hA500_0055, 1'b0, 1'b0);
    one("and", 4'b0111, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0);
    one("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1'b0);
    one("illegal", 4'b1001, 32'd5, 32'd7, 32'd0, 1'b1, 1'b1);
    one("add_clr", 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    one("sll0", 4'b0001, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 1'b0, 1'b0);
    shf("sra", 4'b1101, 32'h8000_0000, 32'd4, 4, 32'hF800_0000);
    shf("srl", 4'b0101, 32'h8000_0000, 32'd4, 4, 32'h0800_0000);
    shf("sll31", 4'b0001, 32'h0000_0001, 32'd31, 31, 32'h8000_0000);
    drive(1'b1, 4'b0001, 32'h0000_0001, 32'd10);
    step();
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("abort_flags", {28'h0, busy, valid, zero, illegal}, 32'h2);
    chk("abort_res", result, 32'h0);
    one("add_post", 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("abort_quiet", {30'h0, busy, valid}, 32'h0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
